// File: rtl/seg_pkg.sv
// Shared constants and FSM state type for the segment display path.
package seg_pkg;
  localparam int unsigned SEG_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    LATCH
  } seg_state_e;
endpackage

// File: rtl/seg_p2s_shifter_if.sv
// Frame request / serial output bundle between the display refresher and the shifter.
interface seg_p2s_shifter_if
  import seg_pkg::*;
#(
  parameter int unsigned DATA_W = SEG_DATA_W
);
  logic              start;
  logic [DATA_W-1:0] seg_txt;
  logic              busy;
  logic              done;
  logic              s_clk;
  logic              s_dat;
  logic              s_clr_n;
  logic              s_en;

  modport master (
    output start, seg_txt,
    input  busy, done, s_clk, s_dat, s_clr_n, s_en
  );

  modport slave (
    input  start, seg_txt,
    output busy, done, s_clk, s_dat, s_clr_n, s_en
  );
endinterface

// File: rtl/seg_clk_div.sv
// Half-period tick generator: tick is high on the last of every CLK_DIV cycles.
module seg_clk_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seg_p2s_shifter.sv
// Serialises a segment image MSB first into cascaded shift registers with clear/enable strobes.
module seg_p2s_shifter
  import seg_pkg::*;
#(
  parameter int unsigned DATA_W  = SEG_DATA_W,
  parameter int unsigned CLK_DIV = 2
) (
  input logic             clk,
  input logic             rst_n,
  seg_p2s_shifter_if.slave bus
);
  localparam int unsigned BW = $clog2(DATA_W);

  seg_state_e        state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              hi_q, hi_d;
  logic              written_q, written_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              s_clk_q, s_clk_d;
  logic              s_dat_q, s_dat_d;
  logic              s_clr_n_q, s_clr_n_d;
  logic              s_en_q, s_en_d;
  logic              tick;

  // Divider held at zero in IDLE so every frame starts phase-aligned.
  seg_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    hi_d      = hi_q;
    written_d = written_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    s_clk_d   = s_clk_q;
    s_dat_d   = s_dat_q;
    s_clr_n_d = s_clr_n_q;
    s_en_d    = s_en_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = CLEAR;
          sh_d      = bus.seg_txt;
          bit_d     = '0;
          hi_d      = 1'b0;
          busy_d    = 1'b1;
          s_clk_d   = 1'b0;
          s_clr_n_d = 1'b0;
          s_en_d    = 1'b0;
        end
      end
      CLEAR: begin
        if (tick) begin
          state_d   = SHIFT;
          s_clr_n_d = 1'b1;
          s_en_d    = written_q;
          s_dat_d   = sh_q[DATA_W-1];
          sh_d      = {sh_q[DATA_W-2:0], 1'b0};
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!hi_q) begin
            hi_d    = 1'b1;
            s_clk_d = 1'b1;
          end else begin
            hi_d    = 1'b0;
            s_clk_d = 1'b0;
            if (bit_q == BW'(DATA_W - 1)) begin
              bit_d   = '0;
              state_d = LATCH;
            end else begin
              bit_d   = bit_q + 1'b1;
              s_dat_d = sh_q[DATA_W-1];
              sh_d    = {sh_q[DATA_W-2:0], 1'b0};
            end
          end
        end
      end
      LATCH: begin
        if (tick) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          written_d = 1'b1;
          s_en_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      bit_q     <= '0;
      hi_q      <= 1'b0;
      written_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s_clk_q   <= 1'b0;
      s_dat_q   <= 1'b0;
      s_clr_n_q <= 1'b1;
      s_en_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_q     <= bit_d;
      hi_q      <= hi_d;
      written_q <= written_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      s_clk_q   <= s_clk_d;
      s_dat_q   <= s_dat_d;
      s_clr_n_q <= s_clr_n_d;
      s_en_q    <= s_en_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.s_clk   = s_clk_q;
  assign bus.s_dat   = s_dat_q;
  assign bus.s_clr_n = s_clr_n_q;
  assign bus.s_en    = s_en_q;
endmodule
